dual_port_ram_p: RTL and testbench
==================================

DUAL_PORT_RAM_P -- requirements
Module: dual_port_ram_p

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter DEPTH, default 1024, number of words; any value >= 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 Parameter RDW_MODE, default READ_FIRST, cross-port read-during-write result (READ_FIRST or WRITE_FIRST).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all state on posedge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 a_cs / b_cs  input  1  port chip select.
REQ-009 a_we / b_we  input  1  write enable, 1 = write, 0 = read.
REQ-010 a_oe / b_oe  input  1  output enable, qualifies reads.
REQ-011 a_addr / b_addr  input  ADDR_W  word address.
REQ-012 a_wdata / b_wdata  input  DATA_W  write data.
REQ-013 a_rdata / b_rdata  output  DATA_W  registered read data.
REQ-014 a_rvalid / b_rvalid  output  1  one-cycle pulse marking valid rdata.
REQ-015 init_busy  output  1  high while clear sequence runs.
REQ-016 collision  output  1  one-cycle pulse on same-address dual write.

Function
REQ-017 FSM states: CLEAR, READY; reset enters CLEAR with clear counter 0.
REQ-018 CLEAR: writes 0 to one address per cycle, 0..DEPTH-1; moves to READY the cycle after DEPTH-1 is written; init_busy=1 throughout, and 0 in READY.
REQ-019 During CLEAR, all port requests are ignored: no writes, rvalid stays 0.
REQ-020 READY write: cs & we writes wdata to addr at the clock edge; rvalid stays 0.
REQ-021 READY read: cs & !we & oe gives rdata = mem[addr] and rvalid=1 one cycle later (latency 1); rdata holds its value otherwise.
REQ-022 cs & !we & !oe: no operation, rdata holds, rvalid=0.
REQ-023 Both ports write the same address in one cycle: port A data is stored, and collision=1 on the next cycle for one cycle.
REQ-024 One port writes and the other reads the same address: with READ_FIRST the read returns the old word; with WRITE_FIRST it returns the new word.
REQ-025 addr >= DEPTH: the write is dropped; a read returns 0 with rvalid=1.
REQ-026 Both ports reading the same address is legal and both return the same word.

Reset
REQ-027 While reset=0: rdata=0, rvalid=0, collision=0, init_busy=1, clear counter=0, state=CLEAR.
REQ-028 Reset asserted mid-CLEAR or mid-READY aborts all activity; the clear sequence restarts from address 0 after release.
REQ-029 Memory array has no direct reset; contents are zeroed only by the CLEAR sequence.

Configuration
REQ-030 Macro DUAL_PORT_RAM_P_OUT_REG_EN defined: each port adds a second output register stage, giving read latency 2; rdata and rvalid are delayed together; collision timing is unchanged.
REQ-031 Macro undefined: read latency is 1, as in REQ-021.

Structure
REQ-032 Package dpram_pkg holds rdw_mode_e {READ_FIRST, WRITE_FIRST}, state_e {CLEAR, READY}, and default constants DPRAM_DATA_W=8 and DPRAM_DEPTH=1024.
REQ-033 Sub-module dpram_rd_pipe (one instance per port) implements the output register stage(s), including the macro-controlled second stage.

Verification
REQ-034 Reset release, DEPTH=16 -> init_busy=1 for exactly 16 cycles; reads of all addresses then return 0.
REQ-035 A writes 0xA5 @ addr 3, next cycle B reads addr 3 -> b_rdata=0xA5 and b_rvalid=1, one cycle later (two with macro).
REQ-036 A writes 0x11 and B writes 0x22 @ addr 7 in the same cycle -> collision pulses once; later read of addr 7 = 0x11.
REQ-037 mem[5]=0x33; A writes 0x44 @ addr 5 while B reads addr 5 -> READ_FIRST returns 0x33, WRITE_FIRST returns 0x44.
REQ-038 reset pulsed low during CLEAR at counter=9 -> outputs return to reset values; clear restarts at 0 and runs the full DEPTH cycles.
REQ-039 DEPTH=12, read addr 13 -> rdata=0, rvalid=1; write addr 13 -> no memory location changes.

Source files
------------

// File: rtl/dual_port_ram_p_pkg.sv
// Shared types, default sizes and a range helper for the dual-port RAM.
// Optional DUAL_PORT_RAM_P_OUT_REG_EN (see dpram_rd_pipe) adds a second output stage.
package dpram_pkg;

   typedef enum logic {
      READ_FIRST  = 1'b0,
      WRITE_FIRST = 1'b1
   } rdw_mode_e;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   localparam int DPRAM_DATA_W = 8;
   localparam int DPRAM_DEPTH  = 1024;

   // Addresses past the last word are legal on the bus but never touch memory.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/dual_port_ram_p_rd_pipe.sv
// Per-port read output register: one stage by default, two when
// DUAL_PORT_RAM_P_OUT_REG_EN is defined. rdata holds between valid reads.
module dpram_rd_pipe #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] rd_word,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid
);

   logic [DATA_W-1:0] s1_data_reg;
   logic              s1_valid_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_data_reg  <= '0;
         s1_valid_reg <= 1'b0;
      end else begin
         s1_valid_reg <= rd_en;
         if (rd_en) begin
            s1_data_reg <= rd_word;
         end
      end
   end

`ifdef DUAL_PORT_RAM_P_OUT_REG_EN
   logic [DATA_W-1:0] s2_data_reg;
   logic              s2_valid_reg;

   // Data and valid move together so the hold behaviour matches the single-stage build.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_data_reg  <= '0;
         s2_valid_reg <= 1'b0;
      end else begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_data_reg <= s1_data_reg;
         end
      end
   end

   assign rdata  = s2_data_reg;
   assign rvalid = s2_valid_reg;
`else
   assign rdata  = s1_data_reg;
   assign rvalid = s1_valid_reg;
`endif

endmodule

// File: rtl/dual_port_ram_p.sv
// True dual-port RAM that zeroes itself after reset, with selectable cross-port
// read-during-write result. Define DUAL_PORT_RAM_P_OUT_REG_EN for read latency 2.
module dual_port_ram_p
   import dpram_pkg::*;
#(
   parameter int        DATA_W   = DPRAM_DATA_W,
   parameter int        DEPTH    = DPRAM_DEPTH,
   parameter int        ADDR_W   = $clog2(DEPTH),
   parameter rdw_mode_e RDW_MODE = READ_FIRST
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_cs,
   input  logic              a_we,
   input  logic              a_oe,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   input  logic              b_cs,
   input  logic              b_we,
   input  logic              b_oe,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid,
   output logic              init_busy,
   output logic              collision
);

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

   state_e            state_reg, state_next;
   logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
   logic              collision_reg;
   logic              ready;

   logic [DATA_W-1:0] mem [DEPTH];

   // Port signals gathered into arrays so per-port logic is written once.
   logic [1:0]        cs_v, we_v, oe_v;
   logic [ADDR_W-1:0] addr_v  [2];
   logic [DATA_W-1:0] wdata_v [2];
   logic [DATA_W-1:0] rdata_v [2];
   logic [1:0]        rvalid_v;
   logic [1:0]        wr_v, rd_v, ok_v, wr_ok_v;

   assign cs_v       = {b_cs, a_cs};
   assign we_v       = {b_we, a_we};
   assign oe_v       = {b_oe, a_oe};
   assign addr_v[0]  = a_addr;
   assign addr_v[1]  = b_addr;
   assign wdata_v[0] = a_wdata;
   assign wdata_v[1] = b_wdata;

   assign ready = (state_reg == READY);

   // Clear-sequence controller
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= CLEAR;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      case (state_reg)
         CLEAR: begin
            if (clr_cnt_reg == CLR_LAST) begin
               state_next   = READY;
               clr_cnt_next = '0;
            end else begin
               clr_cnt_next = clr_cnt_reg + 1'b1;
            end
         end
         READY: begin
            state_next = READY;
         end
         default: begin
            state_next   = CLEAR;
            clr_cnt_next = '0;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         localparam int OTHER = 1 - gi;

         logic [DATA_W-1:0] rd_word;

         assign wr_v[gi]    = ready & cs_v[gi] & we_v[gi];
         assign rd_v[gi]    = ready & cs_v[gi] & ~we_v[gi] & oe_v[gi];
         assign ok_v[gi]    = addr_in_range(32'(addr_v[gi]), DEPTH);
         assign wr_ok_v[gi] = wr_v[gi] & ok_v[gi];

         // WRITE_FIRST forwards the other port's same-cycle write; READ_FIRST sees the stored word.
         always_comb begin
            rd_word = '0;
            if (ok_v[gi]) begin
               rd_word = mem[addr_v[gi]];
               if (RDW_MODE == WRITE_FIRST && wr_ok_v[OTHER] && addr_v[OTHER] == addr_v[gi]) begin
                  rd_word = wdata_v[OTHER];
               end
            end
         end

         dpram_rd_pipe #(
            .DATA_W (DATA_W)
         ) u_rd_pipe (
            .clk     (clk),
            .reset   (reset),
            .rd_en   (rd_v[gi]),
            .rd_word (rd_word),
            .rdata   (rdata_v[gi]),
            .rvalid  (rvalid_v[gi])
         );
      end
   endgenerate

   // Port B is applied first so port A wins a same-address dual write.
   always_ff @(posedge clk) begin
      if (state_reg == CLEAR) begin
         mem[clr_cnt_reg] <= '0;
      end else begin
         if (wr_ok_v[1]) begin
            mem[addr_v[1]] <= wdata_v[1];
         end
         if (wr_ok_v[0]) begin
            mem[addr_v[0]] <= wdata_v[0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         collision_reg <= 1'b0;
      end else begin
         collision_reg <= wr_v[0] & wr_v[1] & (addr_v[0] == addr_v[1]);
      end
   end

   assign a_rdata   = rdata_v[0];
   assign a_rvalid  = rvalid_v[0];
   assign b_rdata   = rdata_v[1];
   assign b_rvalid  = rvalid_v[1];
   assign init_busy = (state_reg == CLEAR);
   assign collision = collision_reg;

endmodule

// File: tb/tb_dual_port_ram_p.sv
// Bench for dual_port_ram_p: a 12-word READ_FIRST instance and a 16-word
// WRITE_FIRST instance share one stimulus stream and are checked against a model.
module tb_dual_port_ram_p;
   import dpram_pkg::*;

`ifdef DUAL_PORT_RAM_P_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       cs    [2];
   logic       we    [2];
   logic       oe    [2];
   logic [3:0] addr  [2];
   logic [7:0] wdata [2];

   logic [7:0] rdata_o  [2][2];
   logic       rvalid_o [2][2];
   logic       coll_o   [2];
   logic       busy_o   [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dual_port_ram_p #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .RDW_MODE(READ_FIRST)) dut0 (
      .clk(clk), .reset(reset),
      .a_cs(cs[0]), .a_we(we[0]), .a_oe(oe[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
      .a_rdata(rdata_o[0][0]), .a_rvalid(rvalid_o[0][0]),
      .b_cs(cs[1]), .b_we(we[1]), .b_oe(oe[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
      .b_rdata(rdata_o[0][1]), .b_rvalid(rvalid_o[0][1]),
      .init_busy(busy_o[0]), .collision(coll_o[0])
   );

   dual_port_ram_p #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .RDW_MODE(WRITE_FIRST)) dut1 (
      .clk(clk), .reset(reset),
      .a_cs(cs[0]), .a_we(we[0]), .a_oe(oe[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
      .a_rdata(rdata_o[1][0]), .a_rvalid(rvalid_o[1][0]),
      .b_cs(cs[1]), .b_we(we[1]), .b_oe(oe[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
      .b_rdata(rdata_o[1][1]), .b_rvalid(rvalid_o[1][1]),
      .init_busy(busy_o[1]), .collision(coll_o[1])
   );

   // ---------------- behavioural model ----------------
   int         depth_m [2] = '{12, 16};
   bit         wf_m    [2] = '{1'b0, 1'b1};
   logic [7:0] mmem    [2][16];
   bit         clearing[2];
   int         clr_idx [2];
   logic [7:0] exp_rdata [2][2];
   logic       exp_rvalid[2][2];
   logic       exp_coll  [2];
   logic       exp_busy  [2];
   logic [7:0] pend_d [2][2];
   logic       pend_v [2][2];
   logic [7:0] res_d  [2];
   logic       res_v  [2];
   logic       res_coll;

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         clearing[k] = 1'b1;
         clr_idx[k]  = 0;
         exp_coll[k] = 1'b0;
         exp_busy[k] = 1'b1;
         for (int p = 0; p < 2; p++) begin
            exp_rdata[k][p]  = 8'h00;
            exp_rvalid[k][p] = 1'b0;
            pend_d[k][p]     = 8'h00;
            pend_v[k][p]     = 1'b0;
         end
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         res_coll = 1'b0;
         for (int p = 0; p < 2; p++) begin
            res_v[p] = 1'b0;
            res_d[p] = 8'h00;
         end
         if (clearing[k]) begin
            mmem[k][clr_idx[k]] = 8'h00;
            clr_idx[k]++;
            if (clr_idx[k] == depth_m[k]) clearing[k] = 1'b0;
         end else begin
            for (int p = 0; p < 2; p++) begin
               if (cs[p] && !we[p] && oe[p]) begin
                  res_v[p] = 1'b1;
                  if (int'(addr[p]) >= depth_m[k])
                     res_d[p] = 8'h00;
                  else if (wf_m[k] && cs[1-p] && we[1-p] && addr[1-p] == addr[p])
                     res_d[p] = wdata[1-p];
                  else
                     res_d[p] = mmem[k][addr[p]];
               end
            end
            res_coll = cs[0] && we[0] && cs[1] && we[1] && addr[0] == addr[1];
            if (cs[1] && we[1] && int'(addr[1]) < depth_m[k]) mmem[k][addr[1]] = wdata[1];
            if (cs[0] && we[0] && int'(addr[0]) < depth_m[k]) mmem[k][addr[0]] = wdata[0];
         end
         exp_busy[k] = clearing[k];
         exp_coll[k] = res_coll;
         for (int p = 0; p < 2; p++) begin
            if (LAT == 1) begin
               exp_rvalid[k][p] = res_v[p];
               if (res_v[p]) exp_rdata[k][p] = res_d[p];
            end else begin
               exp_rvalid[k][p] = pend_v[k][p];
               if (pend_v[k][p]) exp_rdata[k][p] = pend_d[k][p];
               pend_v[k][p] = res_v[p];
               if (res_v[p]) pend_d[k][p] = res_d[p];
            end
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_reset();
         else        model_edge();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      #2;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d init_busy", k), 32'(busy_o[k]), 32'(exp_busy[k]));
            chk($sformatf("dut%0d collision", k), 32'(coll_o[k]), 32'(exp_coll[k]));
            for (int p = 0; p < 2; p++) begin
               chk($sformatf("dut%0d p%0d rvalid", k, p), 32'(rvalid_o[k][p]), 32'(exp_rvalid[k][p]));
               chk($sformatf("dut%0d p%0d rdata", k, p), 32'(rdata_o[k][p]), 32'(exp_rdata[k][p]));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic string pdesc(input int p);
      if (!cs[p]) return "idle";
      if (we[p])  return $sformatf("wr[%0d]=%02h", addr[p], wdata[p]);
      if (oe[p])  return $sformatf("rd[%0d]", addr[p]);
      return "nop";
   endfunction

   task automatic idle();
      for (int p = 0; p < 2; p++) begin
         cs[p] = 1'b0; we[p] = 1'b0; oe[p] = 1'b0; addr[p] = 4'd0; wdata[p] = 8'h00;
      end
   endtask

   task automatic set_wr(input int p, input logic [3:0] ad, input logic [7:0] d);
      cs[p] = 1'b1; we[p] = 1'b1; oe[p] = 1'b0; addr[p] = ad; wdata[p] = d;
   endtask

   task automatic set_rd(input int p, input logic [3:0] ad);
      cs[p] = 1'b1; we[p] = 1'b0; oe[p] = 1'b1; addr[p] = ad; wdata[p] = 8'h00;
   endtask

   task automatic set_nop(input int p, input logic [3:0] ad);
      cs[p] = 1'b1; we[p] = 1'b0; oe[p] = 1'b0; addr[p] = ad; wdata[p] = 8'h00;
   endtask

   task automatic tick();
      $display("[TB] txn A:%s B:%s", pdesc(0), pdesc(1));
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic wait_rd();
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic count_busy(output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy_o[0]) c0++;
         if (busy_o[1]) c1++;
      end
   endtask

   task automatic read_all();
      for (int a = 0; a < 16; a++) begin
         set_rd(0, 4'(a));
         set_rd(1, 4'(15 - a));
         tick();
      end
   endtask

   // ---------------- directed sequence ----------------
   int c0, c1;

   initial begin
      idle();
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy0", 32'(busy_o[0]), 32'd1);
      chk("reset rvalid0", 32'(rvalid_o[0][0]), 32'd0);

      @(posedge clk);
      #1 reset = 1'b1;
      count_busy(c0, c1);
      chk("clear length depth12", 32'(c0), 32'd12);
      chk("clear length depth16", 32'(c1), 32'd16);

      read_all();

      // A writes 0xA5 @3, B reads it next cycle
      set_wr(0, 4'd3, 8'hA5); tick();
      set_rd(1, 4'd3);        tick();
      wait_rd();
      chk("rd after wr data", 32'(rdata_o[0][1]), 32'hA5);
      chk("rd after wr valid", 32'(rvalid_o[0][1]), 32'd1);

      // same-address dual write
      set_wr(0, 4'd7, 8'h11); set_wr(1, 4'd7, 8'h22); tick();
      @(negedge clk);
      chk("collision pulse dut0", 32'(coll_o[0]), 32'd1);
      chk("collision pulse dut1", 32'(coll_o[1]), 32'd1);
      set_rd(0, 4'd7); tick();
      wait_rd();
      chk("collision winner", 32'(rdata_o[0][0]), 32'h11);

      // cross-port read during write
      set_wr(0, 4'd5, 8'h33); tick();
      set_wr(0, 4'd5, 8'h44); set_rd(1, 4'd5); tick();
      wait_rd();
      chk("read_first old word", 32'(rdata_o[0][1]), 32'h33);
      chk("write_first new word", 32'(rdata_o[1][1]), 32'h44);

      // out-of-range read and write on the 12-word instance
      set_rd(0, 4'd13); tick();
      wait_rd();
      chk("oob read data", 32'(rdata_o[0][0]), 32'h00);
      chk("oob read valid", 32'(rvalid_o[0][0]), 32'd1);
      set_wr(0, 4'd13, 8'h5C); tick();
      set_rd(0, 4'd13); tick();
      wait_rd();
      chk("in-range 13 on depth16", 32'(rdata_o[1][0]), 32'h5C);
      read_all();

      // both ports read the same word; then a no-op that must hold rdata
      set_rd(0, 4'd3); set_rd(1, 4'd3); tick();
      set_nop(0, 4'd7); set_nop(1, 4'd5); tick();
      repeat (2) tick();

      // mixed traffic, every fourth cycle B reads the address A writes
      for (int i = 0; i < 32; i++) begin
         set_wr(0, 4'(i % 16), 8'(i * 7 + 1));
         set_rd(1, (i % 4 == 0) ? 4'(i % 16) : 4'((i + 5) % 16));
         tick();
      end
      read_all();
      set_rd(0, 4'd15); tick();
      wait_rd();
      chk("addr15 depth16", 32'(rdata_o[1][0]), 32'hDA);
      chk("addr15 depth12 oob", 32'(rdata_o[0][0]), 32'h00);

      // reset mid-READY, then again mid-CLEAR at counter 9
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset clears rdata", 32'(rdata_o[1][0]), 32'h00);
      chk("reset busy", 32'(busy_o[1]), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (9) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid-clear reset busy", 32'(busy_o[0]), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      count_busy(c0, c1);
      chk("restart clear depth12", 32'(c0), 32'd12);
      chk("restart clear depth16", 32'(c1), 32'd16);
      read_all();
      set_rd(0, 4'd7); set_rd(1, 4'd13); tick();
      wait_rd();
      chk("cleared addr7", 32'(rdata_o[0][0]), 32'h00);
      chk("cleared addr13", 32'(rdata_o[1][1]), 32'h00);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
